// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm tone sample reader.
package alarm_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/alarm_sync_fifo.sv
// Small synchronous FIFO with a synchronous flush; head word is presented
// combinationally on dout.
module alarm_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                cnt;
  logic                         do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/alarm_tone_reader.sv
// Avalon-MM read master: fetches a block of sample words from a fixed-latency
// memory and streams them out through a credit-managed FIFO, with one-shot,
// looped playback and abort.
module alarm_tone_reader #(
  parameter int ADDR_W       = alarm_pkg::ADDR_W,
  parameter int DATA_W       = alarm_pkg::DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              loop,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  import alarm_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        base_q, count_q, idx_q;
  logic                     loop_q, issue_done_q, zero_done_q;
  logic [CW-1:0]            credits_q;
  logic [READ_LATENCY:1]    vld_pipe;
  logic                     issue, load, pop, push, fifo_flush;
  logic                     pipe_empty, finishing, fifo_empty, fifo_full;
  logic [CW-1:0]            fifo_count;

  assign pipe_empty = ~|vld_pipe;
  assign st_valid   = !fifo_empty;
  assign pop        = st_valid && st_ready;
  // Returns arriving after an abort are dropped, including in the abort cycle.
  assign push       = vld_pipe[READ_LATENCY] && (state_q == FETCH) && !abort;

  // Last cycle of a transfer: done pulses and busy drops together here.
  assign finishing = ((state_q == FETCH) && issue_done_q && pipe_empty && (fifo_count == '0)) ||
                     ((state_q == FLUSH) && pipe_empty);

  assign busy = (state_q != IDLE) && !finishing;
  assign done = zero_done_q || finishing;

  assign avm_read       = issue;
  assign avm_chipselect = issue;
  assign avm_address    = issue ? (base_q + idx_q) : '0;
  assign avm_byteenable = BYTEEN_ALL;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, read issue and FIFO flush decisions.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    issue      = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (word_count != '0)) begin
          load    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (finishing) begin
          state_d = IDLE;
        end else if (abort) begin
          fifo_flush = 1'b1;
          state_d    = FLUSH;
        end else begin
          // fifo_full is implied by zero credits; kept as a local safety net.
          issue = (credits_q != '0) && !issue_done_q && !fifo_full;
        end
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        if (finishing) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer descriptor and word index; index wraps to 0 after the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      count_q      <= '0;
      loop_q       <= 1'b0;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
    end else if (load) begin
      base_q       <= base_addr;
      count_q      <= word_count;
      loop_q       <= loop;
      idx_q        <= '0;
      issue_done_q <= 1'b0;
    end else if (issue) begin
      if (idx_q == count_q - ADDR_W'(1)) begin
        idx_q <= '0;
        if (!loop_q) issue_done_q <= 1'b1;
      end else begin
        idx_q <= idx_q + ADDR_W'(1);
      end
    end
  end

  // Zero-length start completes immediately with a one-cycle done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) zero_done_q <= 1'b0;
    else          zero_done_q <= (state_q == IDLE) && start && (word_count == '0);
  end

  // Credits = free FIFO slots not yet claimed by an in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CRED_MAX;
    end else if (state_q != FETCH) begin
      credits_q <= CRED_MAX;
    end else begin
      case ({issue, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Read-latency valid pipeline: stage READ_LATENCY marks readdata capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int k = 2; k <= READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  alarm_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (fifo_flush),
    .din     (avm_readdata),
    .dout    (st_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_alarm_tone_reader.sv
// Self-checking bench for alarm_tone_reader: vector table, hand-written corner
// sequences and randomized transfers against a word-list reference model.
module tb_alarm_tone_reader;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          start = 1'b0, loop = 1'b0, abort = 1'b0, st_ready = 1'b0;
  logic [AW-1:0] base_addr = '0, word_count = '0;
  logic          busy, done, avm_read, avm_chipselect, st_valid;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_readdata = '0, st_data;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alarm_tone_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .loop(loop), .abort(abort), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
  );

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return DW'(a) * 32'h01010101;
  endfunction

  // Memory with one cycle of read latency; garbage when not read.
  always @(posedge clk) avm_readdata <= avm_read ? word_at(avm_address) : 32'hDEADBEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor
  logic          mon_en = 1'b0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int            pop_first, pop_last, done_cnt, done_cyc, busy_bad, stab_bad;
  int            busy_seen, outst, max_outst, last_read_cyc;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  always @(negedge clk) if (mon_en) begin
    if (prev_stall && (!st_valid || st_data !== prev_data)) stab_bad++;
    prev_stall = st_valid && !st_ready;
    prev_data  = st_data;
    if (st_valid && st_ready) begin
      if (data_q.size() == 0) pop_first = cyc;
      pop_last = cyc;
      data_q.push_back(st_data);
      outst--;
    end
    if (avm_read) begin
      addr_q.push_back(avm_address);
      last_read_cyc = cyc;
      outst++;
    end
    if (outst > max_outst) max_outst = outst;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_bad++;
    end
    if (busy) busy_seen++;
  end

  task automatic clear_mon();
    addr_q.delete(); data_q.delete();
    pop_first = -1; pop_last = -1; done_cnt = 0; done_cyc = -1; busy_bad = 0;
    stab_bad = 0; busy_seen = 0; outst = 0; max_outst = 0; last_read_cyc = -1;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k >= 4 && k < 14) ? 1'b0 : (((k / 2) % 2) == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One transfer; inj >= 0 pulses a second (to be ignored) start on cycle inj.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] n, input int rmode,
                          input int inj, output int s, output bit to);
    clear_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    base_addr = b; word_count = n; loop = 1'b0; start = 1'b1; s = cyc;
    st_ready = rdy(rmode, 0);
    to = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == inj) begin start = 1'b1; base_addr = 15'h300; word_count = 15'd2; end
      st_ready = rdy(rmode, k);
      if (done_cnt != 0) begin to = 1'b0; break; end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 mon_en = 1'b0;
  endtask

  task automatic verify(input string nm, input logic [AW-1:0] b, input logic [AW-1:0] n,
                        input int rmode, input int s, input bit to, input int exp_n,
                        input logic [DW-1:0] ef, input logic [DW-1:0] el);
    int bad, lim;
    logic [AW-1:0] a;
    bad = 0;
    chk({nm, ".timeout"}, longint'(to), 0);
    chk({nm, ".done_once"}, done_cnt, 1);
    chk({nm, ".busy_with_done"}, busy_bad, 0);
    chk({nm, ".stall_stable"}, stab_bad, 0);
    chk({nm, ".outstanding_le_depth"}, longint'(max_outst <= FD), 1);
    chk({nm, ".words"}, data_q.size(), exp_n);
    chk({nm, ".reads"}, addr_q.size(), longint'(n));
    lim = (data_q.size() < addr_q.size()) ? data_q.size() : addr_q.size();
    for (int i = 0; i < lim; i++) begin
      a = b + AW'(i);
      if (addr_q[i] !== a || data_q[i] !== word_at(a)) bad++;
    end
    chk({nm, ".stream_mismatches"}, bad, 0);
    if (exp_n > 0 && data_q.size() > 0) begin
      chk({nm, ".first_word"}, data_q[0], ef);
      chk({nm, ".last_word"}, data_q[data_q.size()-1], el);
    end
    if (n == 0) begin
      chk({nm, ".zero_done_lat"}, done_cyc - s, 1);
      chk({nm, ".zero_busy_cycles"}, busy_seen, 0);
    end else if (rmode == 0) begin
      chk({nm, ".first_pop_lat"}, pop_first - s, 3);
      chk({nm, ".back_to_back"}, pop_last - pop_first, longint'(n) - 1);
      chk({nm, ".done_lat"}, done_cyc - s, longint'(n) + 3);
    end
  endtask

  typedef struct {
    logic [AW-1:0] b;
    logic [AW-1:0] n;
    int            rmode;
    int            inj;
    int            exp_n;
    logic [DW-1:0] ef;
    logic [DW-1:0] el;
  } vec_t;

  vec_t vt[6];

  initial begin
    int s, abort_cyc, bad;
    bit to;
    logic [AW-1:0] rb, rn;

    vt[0] = '{15'h0010, 15'd5, 0, -1, 5, 32'h10101010, 32'h14141414};
    vt[1] = '{15'h0100, 15'd8, 1, -1, 8, 32'h01010100, 32'h08080807};
    vt[2] = '{15'h7FFD, 15'd4, 0, -1, 4, 32'h7D7D7CFD, 32'h00000000};
    vt[3] = '{15'h0000, 15'd1, 2, -1, 1, 32'h00000000, 32'h00000000};
    vt[4] = '{15'h0040, 15'd6, 0,  3, 6, 32'h40404040, 32'h45454545};
    vt[5] = '{15'h0123, 15'd0, 0, -1, 0, 32'h00000000, 32'h00000000};

    // Reset state
    #3;
    chk("reset.outputs", {busy, done, avm_read, avm_chipselect, avm_address, st_valid, st_data}, 0);
    chk("reset.byteenable", avm_byteenable, 4'hF);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Vector table
    foreach (vt[i]) begin
      run_xfer(vt[i].b, vt[i].n, vt[i].rmode, vt[i].inj, s, to);
      verify($sformatf("vec%0d", i), vt[i].b, vt[i].n, vt[i].rmode, s, to,
             vt[i].exp_n, vt[i].ef, vt[i].el);
    end

    // Looped playback across the address wrap, then abort
    clear_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    base_addr = 15'h7FFE; word_count = 15'd3; loop = 1'b1; start = 1'b1; st_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; loop = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("loop.no_done", done_cnt, 0);
    chk("loop.streaming", st_valid, 1);
    abort = 1'b1;
    abort_cyc = cyc;
    @(negedge clk);
    chk("loop.abort_no_issue", avm_read, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("loop.abort_flushed", st_valid, 0);
    chk("loop.abort_done", {done, busy}, 2'b10);
    repeat (8) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("loop.reads", addr_q.size(), 12);
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] !== AW'(32'h7FFE + (i % 3))) bad++;
    foreach (data_q[i]) if (data_q[i] !== word_at(AW'(32'h7FFE + (i % 3)))) bad++;
    chk("loop.wrap_stream_mismatches", bad, 0);
    chk("loop.pops", data_q.size(), 11);
    chk("loop.no_read_after_abort", longint'(last_read_cyc < abort_cyc), 1);
    chk("loop.done_once", done_cnt, 1);
    chk("loop.done_cycle", done_cyc - abort_cyc, 1);

    // start and abort together while busy: abort wins
    clear_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    base_addr = 15'h0200; word_count = 15'd8; start = 1'b1; st_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("collide.pre_valid", st_valid, 1);
    start = 1'b1; abort = 1'b1; base_addr = 15'h0400; word_count = 15'd2;
    abort_cyc = cyc;
    @(negedge clk);
    chk("collide.no_issue", avm_read, 0);
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("collide.flushed", st_valid, 0);
    chk("collide.done", {done, busy}, 2'b10);
    repeat (6) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("collide.no_read_after", longint'(last_read_cyc < abort_cyc), 1);
    chk("collide.done_once", done_cnt, 1);
    chk("collide.idle_after", busy, 0);

    // Asynchronous reset in the middle of a transfer
    @(posedge clk); #1;
    base_addr = 15'h0500; word_count = 15'd10; start = 1'b1; st_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid.pre_active", {avm_read, st_valid, busy}, 3'b111);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid.outputs_zero",
        {busy, done, avm_read, avm_chipselect, avm_address, st_valid, st_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_xfer(15'h0050, 15'd4, 0, -1, s, to);
    verify("rst_mid.after", 15'h0050, 15'd4, 0, s, to, 4, 32'h50505050, 32'h53535353);

    // Randomized transfers against the word-list model
    for (int r = 0; r < 8; r++) begin
      rb = AW'($urandom_range(0, 32767));
      rn = AW'($urandom_range(1, 12));
      run_xfer(rb, rn, 2, -1, s, to);
      verify($sformatf("rand%0d", r), rb, rn, 2, s, to, int'(rn),
             word_at(rb), word_at(rb + rn - AW'(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_tone_reader.md
Name: alarm_tone_reader

Overview:
- Avalon-MM read master paired with the on-chip program/data memory slave, which has fixed read latency and no waitrequest.
- Fetches a block of 32-bit words (alarm tone samples) starting at a word address and streams them out over a valid/ready interface to the tone/PWM stage.
- Supports one-shot and looped playback, abort, and back-pressure through a small credit-managed FIFO.

Parameters:
ADDR_W, 15, word-address width of the memory port
DATA_W, 32, data width
READ_LATENCY, 1, cycles from read issue to readdata valid (memory output unregistered)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= READ_LATENCY+1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin transfer (ignored while busy)
base_addr  in  ADDR_W  first word address, sampled on start
word_count  in  ADDR_W  number of words, sampled on start
loop  in  1  sampled on start: 1 = restart at base_addr after last word
abort  in  1  pulse: terminate transfer
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
avm_address  out  ADDR_W  memory word address
avm_chipselect  out  1  asserted with avm_read
avm_read  out  1  read request (always accepted; no waitrequest)
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  DATA_W  memory read data
st_data  out  DATA_W  sample output (FIFO head)
st_valid  out  1  st_data valid
st_ready  in  1  sink accepts when st_valid & st_ready

Behaviour:
- Reset (async assert, sync deassert in the system): state IDLE.
  - busy=0, done=0, avm_read=0, avm_chipselect=0, avm_address=0, st_valid=0, st_data=0.
  - FIFO empty, credits = FIFO_DEPTH.
- FSM states: IDLE, FETCH, FLUSH.
- IDLE:
  - start with word_count>0: latch base, count and loop; idx=0; go to FETCH; busy=1 from the next cycle.
  - start with word_count=0: done=1 the next cycle; stay IDLE; no reads issued.
- FETCH:
  - Issue a read in a cycle when credits>0 and issued<count. avm_address = base+idx, modulo 2^ADDR_W (wraps at 0x7FFF -> 0).
  - The issue cycle decrements credits and increments idx.
  - avm_readdata is written into the FIFO exactly READ_LATENCY cycles after the issue cycle, tracked by a READ_LATENCY-deep valid shift pipeline.
  - Each FIFO pop (st_valid & st_ready) increments credits. Simultaneous issue and pop leave credits unchanged.
  - credits never <0 and never >FIFO_DEPTH. Sustained throughput is 1 word/cycle with st_ready=1.
- Last word (idx==count-1 issued):
  - loop=1: idx returns to 0; the next read uses base_addr with no bubble cycle.
  - loop=0: stop issuing. When the pipeline and FIFO are both empty after the final pop, pulse done for 1 cycle and drop busy in the same cycle; go to IDLE.
- st_valid = FIFO not empty; st_data = FIFO head, held stable while st_valid & !st_ready.
- abort in FETCH: go to FLUSH.
  - Stop issuing immediately, including in the abort cycle.
  - Flush the FIFO (st_valid=0 from the next cycle).
  - Discard in-flight returns.
  - After the pipeline drains (READ_LATENCY cycles): done pulse, busy=0, IDLE, credits=FIFO_DEPTH.
- abort in IDLE: ignored.
- start and abort in the same cycle while busy: abort wins. In IDLE: start wins.
- start while busy: ignored, no state change.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, FETCH, FLUSH}
  - ADDR_W/DATA_W constants
  - BYTEEN_ALL = 4'hF
- One natural sub-module, alarm_sync_fifo: DEPTH×DATA_W, push/pop/flush, empty/full/count, async active-low reset.
- Credit counter and latency pipeline stay in the top level.

Test Plan:
- One-shot: memory model word[n]=n×0x01010101, base=0x10, count=5, st_ready=1 -> st_data 0x10101010..0x14141414 in order, one per cycle after READ_LATENCY+1. done pulses once. busy low the same cycle as done.
- Back-pressure: count=8, st_ready toggled 1/0 every 2 cycles, and held 0 for 10 cycles -> never more than FIFO_DEPTH outstanding, no loss or duplication, data held stable while stalled.
- Address wrap + loop: base=0x7FFE, count=3, loop=1 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x7FFE, …; no done. Then abort -> st_valid=0 next cycle, done after READ_LATENCY cycles, no further avm_read.
- Zero length: start with count=0 -> done=1 the next cycle, avm_read never asserted, busy stays 0.
- Collisions: start+abort in the same cycle while busy -> abort. A start pulse mid-transfer -> ignored, original sequence completes unchanged.
- Reset mid-transfer: reset_n low during FETCH with 3 reads in flight -> all outputs 0 immediately (async). After release, a new start streams correctly from its new base.
